// File: rtl/cordic_vec_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : cordic_vec_ctrl
// Description : Iteration sequencer for a CORDIC vectoring-mode datapath
//               (load, micro-rotations, result handshake). Optional macro
//               CORDIC_QUAD_CORR_EN adds a quadrant pre-rotation step.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module cordic_vec_ctrl #(
    parameter int WORD_WIDTH = `WORD_WIDTH,
    parameter int ITERATIONS = 16,
    parameter int ITER_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_valid_i,
    output logic                  start_ready_o,
    input  logic                  abort_i,
    input  logic                  y_sign_i,
`ifdef CORDIC_QUAD_CORR_EN
    input  logic                  start_x_neg_i,
    output logic                  pre_rot_o,
`endif
    output logic                  load_o,
    output logic                  iter_en_o,
    output logic [ITER_WIDTH-1:0] iter_idx_o,
    output logic                  dir_o,
    output logic                  busy_o,
    output logic                  result_valid_o,
    input  logic                  result_ready_i
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_LOAD   = 3'd1;
    localparam logic [2:0] c_ITER   = 3'd2;
    localparam logic [2:0] c_DONE   = 3'd3;
`ifdef CORDIC_QUAD_CORR_EN
    localparam logic [2:0] c_PREROT = 3'd4;
`endif

    localparam logic [ITER_WIDTH-1:0] c_LAST = ITER_WIDTH'(ITERATIONS - 1);

    logic [2:0]            state_q, state_d;
    logic [ITER_WIDTH-1:0] iter_idx_q, iter_idx_d;
    logic                  load_q, load_d;
    logic                  iter_en_q, iter_en_d;
    logic                  busy_q, busy_d;
    logic                  result_valid_q, result_valid_d;
`ifdef CORDIC_QUAD_CORR_EN
    logic                  x_neg_q, x_neg_d;
    logic                  pre_rot_q, pre_rot_d;
`endif

    always_comb begin
        state_d    = state_q;
        iter_idx_d = '0;
`ifdef CORDIC_QUAD_CORR_EN
        x_neg_d    = x_neg_q;
`endif
        case (state_q)
            c_IDLE: begin
                if (start_valid_i) begin
                    state_d = c_LOAD;
`ifdef CORDIC_QUAD_CORR_EN
                    x_neg_d = start_x_neg_i;
`endif
                end
            end
            c_LOAD: begin
                if (abort_i) begin
                    state_d = c_IDLE;
                end else begin
`ifdef CORDIC_QUAD_CORR_EN
                    state_d = x_neg_q ? c_PREROT : c_ITER;
`else
                    state_d = c_ITER;
`endif
                end
            end
`ifdef CORDIC_QUAD_CORR_EN
            c_PREROT: begin
                state_d = abort_i ? c_IDLE : c_ITER;
            end
`endif
            c_ITER: begin
                if (abort_i) begin
                    state_d = c_IDLE;
                end else if (iter_idx_q == c_LAST) begin
                    state_d = c_DONE;
                end else begin
                    iter_idx_d = iter_idx_q + 1'b1;
                end
            end
            c_DONE: begin
                if (result_ready_i) begin
                    state_d = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        load_d         = (state_d == c_LOAD);
        iter_en_d      = (state_d == c_ITER);
        result_valid_d = (state_d == c_DONE);
`ifdef CORDIC_QUAD_CORR_EN
        pre_rot_d      = (state_d == c_PREROT);
        busy_d         = load_d | iter_en_d | pre_rot_d;
`else
        busy_d         = load_d | iter_en_d;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= c_IDLE;
            iter_idx_q     <= '0;
            load_q         <= 1'b0;
            iter_en_q      <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
`ifdef CORDIC_QUAD_CORR_EN
            x_neg_q        <= 1'b0;
            pre_rot_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            iter_idx_q     <= iter_idx_d;
            load_q         <= load_d;
            iter_en_q      <= iter_en_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
`ifdef CORDIC_QUAD_CORR_EN
            x_neg_q        <= x_neg_d;
            pre_rot_q      <= pre_rot_d;
`endif
        end
    end

    assign start_ready_o  = (state_q == c_IDLE);
    assign load_o         = load_q;
    assign iter_en_o      = iter_en_q;
    assign iter_idx_o     = iter_idx_q;
    assign busy_o         = busy_q;
    assign result_valid_o = result_valid_q;
    // y_sign reflects the y produced at the previous edge, so dir is combinational.
    assign dir_o          = iter_en_q & ~y_sign_i;
`ifdef CORDIC_QUAD_CORR_EN
    assign pre_rot_o      = pre_rot_q;
`endif

    // A shift amount at or beyond the word width would zero the operand.
    a_shift_in_range : assert property (@(posedge clk) disable iff (rst)
        iter_en_q |-> (int'(iter_idx_q) < WORD_WIDTH));

endmodule

`default_nettype wire

// File: tb/tb_cordic_vec_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_cordic_vec_ctrl
// Description : Directed, table-driven bench for cordic_vec_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_vec_ctrl;

    localparam int ITER = 16;
    localparam int IW   = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_valid, abort, y_sign, result_ready;
    logic          start_ready, load, iter_en, dir, busy, result_valid;
    logic [IW-1:0] iter_idx;
`ifdef CORDIC_QUAD_CORR_EN
    logic          start_x_neg, pre_rot;
`endif

    // Second instance with a single micro-rotation
    logic          a_sv, a_ready, a_load, a_ie, a_dir, a_busy, a_rv;
    logic [IW-1:0] a_idx;
`ifdef CORDIC_QUAD_CORR_EN
    logic          a_pre_rot;
`endif

    cordic_vec_ctrl #(.ITERATIONS(ITER), .ITER_WIDTH(IW)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .start_valid_i  (start_valid),
        .start_ready_o  (start_ready),
        .abort_i        (abort),
        .y_sign_i       (y_sign),
`ifdef CORDIC_QUAD_CORR_EN
        .start_x_neg_i  (start_x_neg),
        .pre_rot_o      (pre_rot),
`endif
        .load_o         (load),
        .iter_en_o      (iter_en),
        .iter_idx_o     (iter_idx),
        .dir_o          (dir),
        .busy_o         (busy),
        .result_valid_o (result_valid),
        .result_ready_i (result_ready)
    );

    cordic_vec_ctrl #(.ITERATIONS(1), .ITER_WIDTH(IW)) u_dut1 (
        .clk            (clk),
        .rst            (rst),
        .start_valid_i  (a_sv),
        .start_ready_o  (a_ready),
        .abort_i        (1'b0),
        .y_sign_i       (1'b0),
`ifdef CORDIC_QUAD_CORR_EN
        .start_x_neg_i  (1'b0),
        .pre_rot_o      (a_pre_rot),
`endif
        .load_o         (a_load),
        .iter_en_o      (a_ie),
        .iter_idx_o     (a_idx),
        .dir_o          (a_dir),
        .busy_o         (a_busy),
        .result_valid_o (a_rv),
        .result_ready_i (1'b1)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a start; returns one step after the acceptance edge (state LOAD).
    task automatic do_start();
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
    endtask

    // Edges from the acceptance edge until result_valid is seen.
    task automatic wait_rv(output int n);
        n = 0;
        while (!result_valid && n < 60) begin
            tick();
            n++;
        end
    endtask

    task automatic run_to_idx(input int k, input string tag);
        int guard;
        guard = 0;
        while (!(iter_en && iter_idx == IW'(k)) && guard < 40) begin
            tick();
            guard++;
        end
        chk({tag, " reached idx"}, iter_idx, k);
    endtask

    typedef struct {
        logic sv, ab, ys, rr;
        logic sr, ld, ie;
        logic [IW-1:0] idx;
        logic dr, bz, rv;
    } vec_t;

    vec_t tbl[20];

    initial begin
        int n, ie_cnt;
        logic saw_rv;

        // Full operation, cycle by cycle (inputs this cycle / outputs this cycle)
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < ITER; k++) begin
            logic ys;
            case (k)
                0: ys = 1'b0;
                1: ys = 1'b1;
                2: ys = 1'b1;
                3: ys = 1'b0;
                default: ys = (k % 2 == 1);
            endcase
            tbl[2+k] = '{1'b0, 1'b0, ys, 1'b1, 1'b0, 1'b0, 1'b1, IW'(k), ~ys, 1'b1, 1'b0};
        end
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        start_valid = 1'b0; abort = 1'b0; y_sign = 1'b0; result_ready = 1'b1;
        a_sv = 1'b0;
`ifdef CORDIC_QUAD_CORR_EN
        start_x_neg = 1'b0;
`endif
        tick();
        start_valid = 1'b1;
        abort = 1'b1;
        tick();
        chk("rst start_ready", start_ready, 1);
        chk("rst load", load, 0);
        chk("rst iter_en", iter_en, 0);
        chk("rst iter_idx", iter_idx, 0);
        chk("rst busy", busy, 0);
        chk("rst result_valid", result_valid, 0);
        start_valid = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Main timing and dir table
        for (int i = 0; i < 20; i++) begin
            start_valid  = tbl[i].sv;
            abort        = tbl[i].ab;
            y_sign       = tbl[i].ys;
            result_ready = tbl[i].rr;
            #1;
            chk($sformatf("row%0d start_ready", i), start_ready, tbl[i].sr);
            chk($sformatf("row%0d load", i), load, tbl[i].ld);
            chk($sformatf("row%0d iter_en", i), iter_en, tbl[i].ie);
            chk($sformatf("row%0d iter_idx", i), iter_idx, tbl[i].idx);
            chk($sformatf("row%0d dir", i), dir, tbl[i].dr);
            chk($sformatf("row%0d busy", i), busy, tbl[i].bz);
            chk($sformatf("row%0d result_valid", i), result_valid, tbl[i].rv);
            tick();
        end

        // Result held under backpressure; starts and abort in DONE ignored
        do_start();
        wait_rv(n);
        chk("bp latency", n, ITER + 1);
        result_ready = 1'b0;
        start_valid  = 1'b1;
        abort        = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("bp%0d result_valid", c), result_valid, 1);
            chk($sformatf("bp%0d start_ready", c), start_ready, 0);
            chk($sformatf("bp%0d load", c), load, 0);
        end
        start_valid  = 1'b0;
        abort        = 1'b0;
        result_ready = 1'b1;
        tick();
        chk("bp release result_valid", result_valid, 0);
        chk("bp release start_ready", start_ready, 1);
        tick();
        chk("bp not queued load", load, 0);
        chk("bp not queued busy", busy, 0);

        // Abort with start in IDLE still accepts; abort at idx 4 cancels
        start_valid = 1'b1;
        abort       = 1'b1;
        tick();
        start_valid = 1'b0;
        abort       = 1'b0;
        chk("idle abort+start load", load, 1);
        run_to_idx(4, "abort");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort iter_en", iter_en, 0);
        chk("abort iter_idx", iter_idx, 0);
        chk("abort busy", busy, 0);
        chk("abort start_ready", start_ready, 1);
        saw_rv = 1'b0;
        for (int c = 0; c < 20; c++) begin
            saw_rv |= result_valid;
            tick();
        end
        chk("abort no result", saw_rv, 0);
        do_start();
        wait_rv(n);
        chk("post-abort latency", n, ITER + 1);
        tick();

        // Asynchronous reset mid-cycle at idx 7
        do_start();
        run_to_idx(7, "areset");
        #3;
        rst = 1'b1;
        #1;
        chk("areset iter_en", iter_en, 0);
        chk("areset iter_idx", iter_idx, 0);
        chk("areset busy", busy, 0);
        chk("areset start_ready", start_ready, 1);
        start_valid = 1'b1;
        tick();
        tick();
        start_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("areset start ignored", load, 0);
        do_start();
        wait_rv(n);
        chk("post-reset latency", n, ITER + 1);
        tick();

        // ITERATIONS=1 instance: one micro-rotation at index 0
        a_sv = 1'b1;
        tick();
        a_sv   = 1'b0;
        n      = 0;
        ie_cnt = 0;
        while (!a_rv && n < 10) begin
            if (a_ie) begin
                ie_cnt++;
                chk("iter1 idx", a_idx, 0);
            end
            tick();
            n++;
        end
        chk("iter1 latency", n, 2);
        chk("iter1 iter_en count", ie_cnt, 1);
        tick();

`ifdef CORDIC_QUAD_CORR_EN
        start_x_neg = 1'b1;
        do_start();
        start_x_neg = 1'b0;
        chk("qc pre_rot at load", pre_rot, 0);
        tick();
        chk("qc pre_rot", pre_rot, 1);
        chk("qc busy", busy, 1);
        chk("qc iter_en", iter_en, 0);
        n = 1;
        while (!result_valid && n < 60) begin
            tick();
            n++;
        end
        chk("qc latency neg", n, ITER + 2);
        tick();
        do_start();
        wait_rv(n);
        chk("qc latency pos", n, ITER + 1);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", n_chk);
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/cordic_vec_ctrl.md
Name: cordic_vec_ctrl

Overview:
Iteration sequencer for the CORDIC vectoring-mode datapath: the x/y/z registers, shifters, adders and the atan ROM.
- Accepts a start request and drives the datapath through one load cycle and ITERATIONS micro-rotations.
- Drives the per-iteration direction from the sign of y, then holds a result-valid handshake until the consumer takes the result.
- Sits between the request source and the datapath; it holds no data words itself.

Parameters:
WORD_WIDTH, `WORD_WIDTH (from settings.h), datapath word width; used only for documentation and assertion consistency.
ITERATIONS, 16, number of micro-rotations per operation; legal range 1..2**ITER_WIDTH.
ITER_WIDTH, 5, width of the iteration index / shift amount.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start_valid  input  1  request to start an operation.
start_ready  output  1  controller can accept a start.
abort  input  1  synchronous cancel of the operation in flight.
y_sign  input  1  MSB of the datapath y register (1 = negative).
load  output  1  datapath loads initial x/y and z=0 this cycle.
iter_en  output  1  datapath performs one micro-rotation this cycle.
iter_idx  output  ITER_WIDTH  shift amount / atan ROM address.
dir  output  1  1 = y>=0: x+=y>>i, y-=x>>i, z+=atan(i); 0 = opposite signs.
busy  output  1  operation in LOAD/ITER (and PREROT if enabled).
result_valid  output  1  datapath x (magnitude) and z (angle) are final.
result_ready  input  1  consumer accepts the result.

Behaviour:
- Reset (rst high, asynchronous): state=IDLE, iter_idx=0, load=0, iter_en=0, busy=0, result_valid=0, start_ready=1.
- Handshakes and the abort input are ignored while rst is high.
- load, iter_en, iter_idx, busy and result_valid are registered.
- start_ready = (state==IDLE).
- dir = ~y_sign when iter_en=1, else 0. dir is combinational; y_sign reflects the y value produced at the previous edge.
- States: IDLE, LOAD, ITER, DONE.
- IDLE: start_valid & start_ready at edge T0 -> LOAD. Cycle T1 has load=1 and busy=1.
- LOAD -> ITER:
  - cycles T2..T(1+ITERATIONS): iter_en=1, busy=1;
  - iter_idx counts 0..ITERATIONS-1, incrementing by 1 per cycle.
- ITER at iter_idx==ITERATIONS-1 -> DONE. iter_idx wraps to 0; iter_en=0.
- DONE: result_valid=1 from cycle T(2+ITERATIONS), so latency is ITERATIONS+2 cycles from acceptance.
  - result_valid is held while result_ready=0.
  - result_valid & result_ready -> IDLE; start_ready=1 the following cycle. There is no same-cycle restart.
- abort in LOAD or ITER -> IDLE next cycle: all outputs return to reset values and no result_valid is produced.
- abort in IDLE or DONE: no effect. In IDLE, abort together with start_valid: the start is accepted.
- start_valid outside IDLE: ignored and not queued.
- ITERATIONS=1: exactly one iter_en cycle with iter_idx=0.

Optional Feature:
Macro: CORDIC_QUAD_CORR_EN.

Defined:
- Adds input start_x_neg (sign of the incoming x, sampled in the acceptance cycle) and output pre_rot (registered, reset 0).
- If start_x_neg was 1, state PREROT is inserted between LOAD and ITER.
  - In PREROT, pre_rot=1 and busy=1 for one cycle.
  - Datapath action in PREROT: x<=-x, y<=-y, z<=+pi if y_sign=0 else -pi.
- Latency becomes ITERATIONS+3.
- abort in PREROT behaves as in ITER.

Undefined:
- start_x_neg and pre_rot are absent; latency is always ITERATIONS+2.

Test Plan:
1. ITERATIONS=16, result_ready=1, start at T0 -> load=1 at T1; iter_en T2..T17 with iter_idx 0..15; result_valid at T18; start_ready=1 at T19.
2. y_sign sequence 0,1,1,0 over iter_idx 0..3 -> dir 1,0,0,1 in the same cycles; dir=0 at T1 and in DONE.
3. result_ready=0 for 5 cycles in DONE, start_valid=1 throughout -> result_valid held, start_ready=0, nothing accepted; result_ready=1 -> IDLE next cycle.
4. abort=1 at iter_idx=4 -> next cycle IDLE, iter_en=0, iter_idx=0, busy=0; no result_valid; next start accepted normally.
5. rst pulsed asynchronously at iter_idx=7 (mid-cycle) -> outputs take reset values immediately; after release, a new start completes with full 18-cycle latency.
6. CORDIC_QUAD_CORR_EN defined, start_x_neg=1 -> pre_rot=1 at T2, iter_en T3..T18, result_valid T19; with start_x_neg=0 -> timing identical to test 1.
